// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes; irq = irq_flag & IM.
// Latency: CTRL write with EN=1 at edge t0 -> COUNT=PRESET after t1, irq_flag set after t(PRESET+2).
// No backpressure: every bus write is accepted in its cycle; optional STATUS register under TC_STATUS_EN.
module timer_counter #(
   parameter int COUNT_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CNT  = 2'd2,
      S_INT  = 2'd3
   } state_t;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_PRESET = 2'd1;
   localparam logic [1:0] ADDR_COUNT  = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   state_t              state_q,     state_d;
   logic                ctrl_en_q,   ctrl_en_d;
   logic [1:0]          ctrl_mode_q, ctrl_mode_d;
   logic                ctrl_im_q,   ctrl_im_d;
   logic [COUNT_W-1:0]  preset_q,    preset_d;
   logic [COUNT_W-1:0]  count_q,     count_d;
   logic                irq_flag_q,  irq_flag_d;

   logic                ctrl_wr;
   logic                preset_wr;
   logic [31:0]         status_rd;

   assign ctrl_wr   = we && (addr == ADDR_CTRL);
   assign preset_wr = we && (addr == ADDR_PRESET);

   // PRESET only changes on a bus write; the running COUNT picks it up at the next LOAD
   always_comb begin
      preset_d = preset_q;
      if (preset_wr) begin
         preset_d = wdata[COUNT_W-1:0];
      end
   end

   // Counter FSM next-state; a CTRL write overrides whatever the FSM would have done this cycle
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      ctrl_en_d   = ctrl_en_q;
      ctrl_mode_d = ctrl_mode_q;
      ctrl_im_d   = ctrl_im_q;
      irq_flag_d  = irq_flag_q;

      case (state_q)
         S_IDLE: begin
            state_d = S_IDLE;
         end
         S_LOAD: begin
            count_d = preset_q;
            state_d = S_CNT;
         end
         S_CNT: begin
            if (!ctrl_en_q) begin
               state_d = S_IDLE;
            end else if (count_q != '0) begin
               count_d = count_q - COUNT_W'(1);
            end else begin
               state_d    = S_INT;
               irq_flag_d = 1'b1;
            end
         end
         S_INT: begin
            // Only mode 1 reloads; modes 0, 2 and 3 all stop after one expiry
            if (ctrl_mode_q == 2'd1) begin
               state_d    = S_LOAD;
               irq_flag_d = 1'b0;
            end else begin
               ctrl_en_d = 1'b0;
               state_d   = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Software write to CTRL: acknowledges any pending irq, discards a same-cycle expiry,
      // and freezes COUNT so a disable mid-count leaves the value software last saw
      if (ctrl_wr) begin
         ctrl_en_d   = wdata[0];
         ctrl_mode_d = wdata[2:1];
         ctrl_im_d   = wdata[3];
         irq_flag_d  = 1'b0;
         count_d     = count_q;
         state_d     = wdata[0] ? S_LOAD : S_IDLE;
      end
   end

   // Register state; reset is asynchronous and active-low
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         preset_q    <= '0;
         ctrl_en_q   <= 1'b0;
         ctrl_mode_q <= 2'd0;
         ctrl_im_q   <= 1'b0;
         irq_flag_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         preset_q    <= preset_d;
         ctrl_en_q   <= ctrl_en_d;
         ctrl_mode_q <= ctrl_mode_d;
         ctrl_im_q   <= ctrl_im_d;
         irq_flag_q  <= irq_flag_d;
      end
   end

`ifdef TC_STATUS_EN
   logic expired_q, expired_d;
   logic expire_evt;

   // A real CNT->INT transition; an expiry swallowed by a CTRL write does not count
   assign expire_evt = (state_q == S_CNT) && ctrl_en_q && (count_q == '0) && !ctrl_wr;

   // Sticky EXPIRED flag: write-1-to-clear, a coincident set wins over the clear
   always_comb begin
      expired_d = expired_q;
      if (we && (addr == ADDR_STATUS) && wdata[0]) begin
         expired_d = 1'b0;
      end
      if (expire_evt) begin
         expired_d = 1'b1;
      end
   end

   // EXPIRED register, unaffected by CTRL writes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         expired_q <= 1'b0;
      end else begin
         expired_q <= expired_d;
      end
   end

   assign status_rd = {31'd0, expired_q};
`else
   assign status_rd = 32'd0;
`endif

   // Combinational read mux; narrow registers are zero-extended
   always_comb begin
      rdata = 32'd0;
      case (addr)
         ADDR_CTRL:   rdata = {28'd0, ctrl_im_q, ctrl_mode_q, ctrl_en_q};
         ADDR_PRESET: rdata = 32'(preset_q);
         ADDR_COUNT:  rdata = 32'(count_q);
         ADDR_STATUS: rdata = status_rd;
         default:     rdata = 32'd0;
      endcase
   end

   assign irq = irq_flag_q & ctrl_im_q;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: vector table for one-shot, hand sequences for the rest.
// Inputs change 1ns after each rising edge; outputs are compared at that same point.
// Covers the STATUS register only when TC_STATUS_EN is defined.
module tb_timer_counter;

   logic        clk;
   logic        reset;
   logic [1:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int n_chk  = 0;
   int n_pass = 0;

   timer_counter #(.COUNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_irq;
   } vec_t;

   vec_t vt [14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one bus cycle, let the edge happen, then release we 1ns later
   task automatic cyc(input logic w, input logic [1:0] a, input logic [31:0] d);
      we    = w;
      addr  = a;
      wdata = d;
      @(posedge clk);
      #1;
      we    = 1'b0;
      wdata = 32'd0;
   endtask

   task automatic tick(input logic [1:0] a);
      cyc(1'b0, a, 32'd0);
   endtask

   initial begin
      logic [31:0] ar_cnt [8];
      int          bad;

      ar_cnt[0] = 32'd5; ar_cnt[1] = 32'd4; ar_cnt[2] = 32'd3; ar_cnt[3] = 32'd2;
      ar_cnt[4] = 32'd1; ar_cnt[5] = 32'd0; ar_cnt[6] = 32'd0; ar_cnt[7] = 32'd0;

      // One-shot table: PRESET=5, CTRL=0x9, irq after 7 edges, then acknowledge with CTRL=0x8
      vt[0]  = '{1'b1, 2'd1, 32'd5,   32'd5, 1'b0};
      vt[1]  = '{1'b1, 2'd0, 32'h9,   32'h9, 1'b0};
      vt[2]  = '{1'b0, 2'd2, 32'd0,   32'd5, 1'b0};
      vt[3]  = '{1'b0, 2'd2, 32'd0,   32'd4, 1'b0};
      vt[4]  = '{1'b0, 2'd2, 32'd0,   32'd3, 1'b0};
      vt[5]  = '{1'b0, 2'd2, 32'd0,   32'd2, 1'b0};
      vt[6]  = '{1'b0, 2'd2, 32'd0,   32'd1, 1'b0};
      vt[7]  = '{1'b0, 2'd2, 32'd0,   32'd0, 1'b0};
      vt[8]  = '{1'b0, 2'd2, 32'd0,   32'd0, 1'b1};
      vt[9]  = '{1'b0, 2'd0, 32'd0,   32'h8, 1'b1};
      vt[10] = '{1'b0, 2'd2, 32'd0,   32'd0, 1'b1};
      vt[11] = '{1'b0, 2'd0, 32'd0,   32'h8, 1'b1};
      vt[12] = '{1'b1, 2'd0, 32'h8,   32'h8, 1'b0};
      vt[13] = '{1'b0, 2'd2, 32'd0,   32'd0, 1'b0};

      // ---- Reset held with bus activity: everything reads 0 ----
      reset = 1'b0;
      we    = 1'b0;
      addr  = 2'd0;
      wdata = 32'd0;
      for (int i = 0; i < 8; i++) begin
         we    = 1'($urandom_range(0, 1));
         addr  = 2'(i % 4);
         wdata = $urandom;
         @(posedge clk);
         #1;
         chk("reset_rdata", rdata, 32'd0);
         chk("reset_irq", {31'd0, irq}, 32'd0);
      end
      we = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         tick(2'(i % 4));
         if (irq !== 1'b0) bad++;
      end
      chk("post_reset_irq_quiet", bad, 0);

      // ---- One-shot via vector table ----
      for (int i = 0; i < 14; i++) begin
         cyc(vt[i].we, vt[i].addr, vt[i].wdata);
         chk($sformatf("oneshot_rdata[%0d]", i), rdata, vt[i].exp_rdata);
         chk($sformatf("oneshot_irq[%0d]", i), {31'd0, irq}, {31'd0, vt[i].exp_irq});
      end

      // ---- Auto-reload: PRESET=5, period 8, single-cycle irq pulse ----
      cyc(1'b1, 2'd0, 32'hB);
      for (int k = 1; k <= 32; k++) begin
         tick(2'd2);
         chk($sformatf("reload_count[%0d]", k), rdata, ar_cnt[(k - 1) % 8]);
         chk($sformatf("reload_irq[%0d]", k), {31'd0, irq}, {31'd0, ((k - 1) % 8) == 6});
      end
      cyc(1'b1, 2'd0, 32'h0);

      // ---- Masked expiry: no irq, EN cleared, COUNT=0 ----
      cyc(1'b1, 2'd1, 32'd3);
      cyc(1'b1, 2'd0, 32'h1);
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         tick(2'd2);
         if (irq !== 1'b0) bad++;
      end
      chk("masked_irq_quiet", bad, 0);
      chk("masked_count", rdata, 32'd0);
      tick(2'd0);
      chk("masked_ctrl_en_cleared", rdata, 32'd0);

      // ---- Mid-count disable freezes COUNT ----
      cyc(1'b1, 2'd1, 32'd20);
      cyc(1'b1, 2'd0, 32'h9);
      for (int i = 0; i < 5; i++) tick(2'd2);
      chk("midcount_before", rdata, 32'd16);
      cyc(1'b1, 2'd0, 32'h8);
      tick(2'd2);
      chk("midcount_frozen_a", rdata, 32'd16);
      tick(2'd2);
      tick(2'd2);
      chk("midcount_frozen_b", rdata, 32'd16);
      chk("midcount_irq", {31'd0, irq}, 32'd0);

      // ---- CTRL write exactly on the expiry edge: no irq, restart from PRESET ----
      cyc(1'b1, 2'd1, 32'd2);
      cyc(1'b1, 2'd0, 32'h9);
      tick(2'd2);
      tick(2'd2);
      tick(2'd2);
      chk("collide_count_zero", rdata, 32'd0);
      cyc(1'b1, 2'd0, 32'h9);
      chk("collide_irq_suppressed", {31'd0, irq}, 32'd0);
      tick(2'd2);
      chk("collide_restart", rdata, 32'd2);
      chk("collide_irq_after", {31'd0, irq}, 32'd0);
      tick(2'd2);
      tick(2'd2);
      tick(2'd2);
      chk("collide_later_expiry", {31'd0, irq}, 32'd1);
      cyc(1'b1, 2'd0, 32'h0);
      chk("collide_ack", {31'd0, irq}, 32'd0);

      // ---- PRESET rewritten while counting from 20 ----
      cyc(1'b1, 2'd1, 32'd20);
      cyc(1'b1, 2'd0, 32'hB);
      tick(2'd2);
      chk("preset_run_start", rdata, 32'd20);
      cyc(1'b1, 2'd1, 32'd10);
      bad = 0;
      for (int i = 3; i <= 21; i++) begin
         tick(2'd2);
         if (irq !== 1'b0) bad++;
      end
      chk("preset_first_quiet", bad, 0);
      tick(2'd2);
      chk("preset_first_expiry", {31'd0, irq}, 32'd1);
      tick(2'd2);
      tick(2'd2);
      chk("preset_reload_value", rdata, 32'd10);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick(2'd2);
         if (irq !== 1'b0) bad++;
      end
      chk("preset_second_quiet", bad, 0);
      tick(2'd2);
      chk("preset_second_expiry", {31'd0, irq}, 32'd1);
      cyc(1'b1, 2'd0, 32'h0);

`ifdef TC_STATUS_EN
      // ---- STATUS: sticky EXPIRED, W1C, set beats clear ----
      cyc(1'b1, 2'd3, 32'd1);
      chk("status_cleared_init", rdata, 32'd0);
      cyc(1'b1, 2'd1, 32'd1);
      cyc(1'b1, 2'd0, 32'h1);
      tick(2'd3);
      tick(2'd3);
      tick(2'd3);
      chk("status_masked_expiry", rdata, 32'd1);
      chk("status_masked_irq", {31'd0, irq}, 32'd0);
      cyc(1'b1, 2'd3, 32'd1);
      chk("status_w1c", rdata, 32'd0);
      cyc(1'b1, 2'd0, 32'h1);
      tick(2'd3);
      tick(2'd3);
      cyc(1'b1, 2'd3, 32'd1);
      chk("status_set_wins", rdata, 32'd1);
`else
      // ---- No STATUS register: addr 3 reads 0 and ignores writes ----
      cyc(1'b1, 2'd3, 32'hFFFF_FFFF);
      chk("status_absent_write", rdata, 32'd0);
      cyc(1'b1, 2'd1, 32'd1);
      cyc(1'b1, 2'd0, 32'h1);
      tick(2'd3);
      tick(2'd3);
      tick(2'd3);
      chk("status_absent_after_expiry", rdata, 32'd0);
`endif

      // ---- Asynchronous reset mid-count ----
      cyc(1'b1, 2'd1, 32'd9);
      cyc(1'b1, 2'd0, 32'h9);
      tick(2'd2);
      tick(2'd2);
      chk("arst_running", rdata, 32'd8);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_count_now", rdata, 32'd0);
      addr = 2'd0;
      #1;
      chk("arst_ctrl_now", rdata, 32'd0);
      addr = 2'd1;
      #0.5;
      chk("arst_preset_now", rdata, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         tick(2'd2);
         if (irq !== 1'b0 || rdata !== 32'd0) bad++;
      end
      chk("arst_quiet_after", bad, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/timer_counter.md
Name: timer_counter

Overview:
- Memory-mapped programmable timer/counter on the CPU's peripheral bus. It is the source of the `interrupt` input of the `mips` core: its `irq` output wires directly to that input.
- Software programs it through CTRL and PRESET registers. It counts down once per clock and raises `irq` on expiry.
- Supports one-shot (mode 0) and auto-reload (mode 1) operation.

Parameters:
- COUNT_W, 32: width of PRESET and COUNT. Legal range 1..32. Read values are zero-extended to 32 bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset. Logic 0 resets immediately, independent of clk.
- addr  input  2  register select (word address bits [3:2]). 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved/STATUS.
- we  input  1  write strobe, sampled on the rising edge of clk.
- wdata  input  32  write data.
- rdata  output  32  read data. Combinational from addr and current register state.
- irq  output  1  interrupt request to the CPU `interrupt` input.

Behaviour:
- Registers:
  - CTRL[0] = EN, CTRL[2:1] = MODE, CTRL[3] = IM (interrupt mask, 1 = enabled). CTRL[31:4] read as 0; writes to those bits are ignored.
  - PRESET is read/write; wdata[COUNT_W-1:0] is stored.
  - COUNT is read-only; writes to it are ignored.
  - MODE 2 and MODE 3 behave exactly as MODE 0.
- Reset values: CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0, irq=0, rdata=0 (with addr at any value).
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: hold COUNT.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT:
    - If EN=0, go to IDLE and hold COUNT.
    - Else if COUNT != 0, COUNT <= COUNT-1.
    - Else (COUNT == 0), go to INT and set irq_flag.
  - INT, MODE 0: clear CTRL.EN and go to IDLE. irq_flag stays set.
  - INT, MODE 1: go to LOAD and clear irq_flag on the same edge, so irq_flag is high for exactly 1 cycle.
- CTRL write (we=1, addr=0) has priority over every FSM transition in the same cycle:
  - CTRL is updated and irq_flag is cleared.
  - Next state is LOAD if the new EN=1, otherwise IDLE.
  - An expiry in the same cycle is discarded, so no irq occurs.
- PRESET write during counting does not affect the running COUNT. The new value takes effect at the next LOAD.
- Timing: with a CTRL write of EN=1 at edge t0 and PRESET=N:
  - LOAD during cycle t0..t1; COUNT=N after t1.
  - COUNT reaches 0 after edge t(N+1).
  - irq_flag is set after edge t(N+2).
  - MODE 1 period = N+3 cycles (LOAD + (N+1) CNT + INT).
- PRESET=0: COUNT=0 after t1, INT after t2.
- irq = irq_flag & CTRL.IM, combinational. In MODE 0, irq stays high until the next CTRL write or reset.
- Changing IM alone requires a CTRL write, which also clears irq_flag. This is the intended acknowledge mechanism.
- Reset asserted mid-count returns everything to reset values immediately. No irq is produced after reset is released.

Optional Feature:
- Macro: TC_STATUS_EN.
- Defined:
  - addr=3 is STATUS. Bit0 = sticky EXPIRED flag, set on every CNT->INT transition regardless of IM. Other bits read as 0.
  - Writing STATUS with wdata[0]=1 clears EXPIRED.
  - If a set and a clear occur in the same cycle, the set wins.
  - Not affected by CTRL writes; reset value 0.
- Undefined: addr=3 reads 0 and writes to it are ignored.

Test Plan:
- Reset: hold reset=0 with we toggling and random wdata -> all reads 0 and irq=0. Release reset -> irq stays 0 for 100 cycles.
- One-shot: PRESET=5, then CTRL=0x9 (EN=1, MODE=0, IM=1) -> irq rises 7 cycles after the CTRL write edge and stays high. CTRL reads 0x8 (EN cleared) and COUNT reads 0. A write of CTRL=0x8 drops irq on the next edge.
- Auto-reload: PRESET=5, CTRL=0xB (MODE=1, IM=1) -> irq is a 1-cycle pulse every 8 cycles for at least 4 periods. COUNT sequence 5,4,3,2,1,0,0 then reload.
- Masking and disable:
  - CTRL=0x1 with PRESET=3 -> expiry occurs (COUNT=0, EN cleared) with irq=0 throughout.
  - Mid-count write CTRL=0x8 -> COUNT freezes at its current value and the state is IDLE.
- Collisions:
  - CTRL write in the exact expiry cycle -> no irq, counting restarts from PRESET.
  - PRESET=10 written while counting from 20 -> current run expires after 20, next run uses 10.
- TC_STATUS_EN defined: masked expiry -> STATUS reads 1. Write wdata=1 to addr 3 -> reads 0. A clear coinciding with an expiry -> reads 1.
